alu_op_sequencer: RTL and testbench

- Initiator side of the 5-bit AND/ADD/OR/XOR ALU interface.
- Accepts a stream of instructions over a valid/ready handshake and drives operands and select to an external combinational ALU instance.
- Captures the ALU result into an internal accumulator and reports completion.
- Turns the stateless ALU into a sequenced accumulator datapath.

---
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_op_sequencer.sv | 103 ++++++++++
 tb/tb_alu_op_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the instruction source, the sequencer and the external ALU.
// master = sequencer side, slave = instruction source / ALU environment side.
`timescale 1ns/1ps
interface alu_op_sequencer_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  // Instruction handshake: a transfer happens on a rising edge where
  // instr_valid && instr_ready; instr_* are don't-care otherwise.
  logic             instr_valid;
  logic             instr_ready;
  logic             instr_load;
  logic [1:0]       instr_op;
  logic [WIDTH-1:0] instr_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;

  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             done;
  logic [CNT_W-1:0] op_count;
  logic             seq_state;  // 0 = IDLE, 1 = EXEC

  modport master (
    input  instr_valid, instr_load, instr_op, instr_imm, alu_result,
    output instr_ready, alu_a, alu_b, alu_sel, acc, carry, done, op_count,
           seq_state
  );

  modport slave (
    output instr_valid, instr_load, instr_op, instr_imm, alu_result,
    input  instr_ready, alu_a, alu_b, alu_sel, acc, carry, done, op_count,
           seq_state
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences load/ALU instructions around an external combinational 5-bit ALU,
// keeping the result in an accumulator and counting retired instructions.
`timescale 1ns/1ps
module alu_op_sequencer #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.master bus
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;

  logic             accept;
  logic [WIDTH-1:0] sum_w;
  logic             add_carry;

  assign bus.instr_ready = (state_q == IDLE) && !rst;
  assign accept          = bus.instr_valid && bus.instr_ready;

  // Carry comes from the registered operands; a wrapped unsigned sum is
  // smaller than either addend exactly when bit WIDTH of the true sum is set.
  assign sum_w     = a_q + b_q;
  assign add_carry = (sel_q == 2'b01) && (sum_w < a_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.instr_load) begin
            acc_d   = bus.instr_imm;
            carry_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            a_d     = acc_q;
            b_d     = bus.instr_imm;
            sel_d   = bus.instr_op;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        acc_d   = bus.alu_result;
        carry_d = add_carry;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.acc       = acc_q;
  assign bus.carry     = carry_q;
  assign bus.done      = done_q;
  assign bus.op_count  = cnt_q;
  assign bus.seq_state = (state_q == EXEC);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus hand-written
// sequences for back-to-back loads, held valid, reset in EXEC and counter wrap.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // external combinational ALU
  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] sel);
    case (sel)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction
  assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

  typedef struct {
    logic             load;
    logic [1:0]       op;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] exp_acc;
    logic             exp_carry;
  } vec_t;

  vec_t vecs[13];

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] model_acc;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ready_in_reset", {31'd0, bus.instr_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_acc", {27'd0, bus.acc}, 32'd0);
    chk("rst_carry", {31'd0, bus.carry}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_cnt", {24'd0, bus.op_count}, 32'd0);
    chk("rst_sel", {30'd0, bus.alu_sel}, 32'd0);
    chk("rst_a", {27'd0, bus.alu_a}, 32'd0);
    model_acc = '0;
    exp_cnt   = '0;
  endtask

  // driver: one instruction, checked through retirement and one idle cycle
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_load  = v.load;
    bus.instr_op    = v.op;
    bus.instr_imm   = v.imm;
    #1;
    chk({tag, "_ready_pre"}, {31'd0, bus.instr_ready}, 32'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_imm   = WIDTH'($urandom_range(0, 31));
    bus.instr_load  = 1'($urandom_range(0, 1));
    if (!v.load) begin
      chk({tag, "_ready_exec"}, {31'd0, bus.instr_ready}, 32'd0);
      chk({tag, "_done_exec"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_sel"}, {30'd0, bus.alu_sel}, {30'd0, v.op});
      chk({tag, "_a"}, {27'd0, bus.alu_a}, {27'd0, model_acc});
      chk({tag, "_b"}, {27'd0, bus.alu_b}, {27'd0, v.imm});
      @(negedge clk);
    end
    exp_cnt++;
    model_acc = v.exp_acc;
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_acc"}, {27'd0, bus.acc}, {27'd0, v.exp_acc});
    chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, v.exp_carry});
    chk({tag, "_cnt"}, {24'd0, bus.op_count}, {24'd0, exp_cnt});
    chk({tag, "_ready_post"}, {31'd0, bus.instr_ready}, 32'd1);
    @(negedge clk);
    chk({tag, "_done_clr"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int accepts, dones, last_acc_cyc, cyc;

    bus.instr_valid = 1'b0;
    bus.instr_load  = 1'b0;
    bus.instr_op    = 2'b00;
    bus.instr_imm   = '0;

    //          load  op     imm        acc        carry
    vecs[0]  = '{1'b1, 2'b00, 5'b10110, 5'b10110, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 5'b01101, 5'b00011, 1'b1};
    vecs[2]  = '{1'b1, 2'b00, 5'b11001, 5'b11001, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 5'b10101, 5'b10001, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 5'b00110, 5'b10111, 1'b0};
    vecs[5]  = '{1'b0, 2'b11, 5'b11111, 5'b01000, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 5'b11000, 5'b00000, 1'b1};
    vecs[7]  = '{1'b0, 2'b01, 5'b00111, 5'b00111, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 5'b11001, 5'b00000, 1'b1};
    vecs[9]  = '{1'b0, 2'b00, 5'b11111, 5'b00000, 1'b0};
    vecs[10] = '{1'b1, 2'b00, 5'b11111, 5'b11111, 1'b0};
    vecs[11] = '{1'b0, 2'b01, 5'b11111, 5'b11110, 1'b1};
    vecs[12] = '{1'b1, 2'b00, 5'b00001, 5'b00001, 1'b0};

    do_reset();
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // back-to-back loads keep done high on consecutive cycles
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_load  = 1'b1;
    bus.instr_imm   = 5'b00011;
    @(negedge clk);
    chk("b2b_done0", {31'd0, bus.done}, 32'd1);
    chk("b2b_acc0", {27'd0, bus.acc}, 32'h03);
    bus.instr_imm = 5'b11100;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("b2b_done1", {31'd0, bus.done}, 32'd1);
    chk("b2b_acc1", {27'd0, bus.acc}, 32'h1c);
    chk("b2b_cnt", {24'd0, bus.op_count}, 32'd15);
    @(negedge clk);
    chk("b2b_done_clr", {31'd0, bus.done}, 32'd0);

    // held valid: four ADD 1 from acc=0, accepted every other cycle
    do_reset();
    accepts = 0;
    dones = 0;
    last_acc_cyc = -10;
    cyc = 0;
    bus.instr_load = 1'b0;
    bus.instr_op   = 2'b01;
    bus.instr_imm  = 5'b00001;
    while (cyc < 40 && (accepts < 4 || dones < 4)) begin
      @(negedge clk);
      if (bus.done) dones++;
      bus.instr_valid = (accepts < 4);
      #1;
      if (bus.instr_valid && bus.instr_ready) begin
        if (accepts > 0)
          chk("hold_spacing", cyc - last_acc_cyc, 32'd2);
        accepts++;
        last_acc_cyc = cyc;
      end
      cyc++;
    end
    bus.instr_valid = 1'b0;
    chk("hold_budget", {31'd0, cyc < 40}, 32'd1);
    chk("hold_accepts", accepts, 32'd4);
    chk("hold_dones", dones, 32'd4);
    chk("hold_acc", {27'd0, bus.acc}, 32'd4);
    chk("hold_cnt", {24'd0, bus.op_count}, 32'd4);
    @(negedge clk);
    chk("hold_no_extra", {31'd0, bus.done}, 32'd0);

    // reset asserted while an ADD is in EXEC
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_load  = 1'b0;
    bus.instr_op    = 2'b01;
    bus.instr_imm   = 5'b11111;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("rexec_state", {31'd0, bus.seq_state}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rexec_acc", {27'd0, bus.acc}, 32'd0);
    chk("rexec_carry", {31'd0, bus.carry}, 32'd0);
    chk("rexec_cnt", {24'd0, bus.op_count}, 32'd0);
    chk("rexec_done", {31'd0, bus.done}, 32'd0);
    chk("rexec_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(negedge clk);
    chk("rexec_done_late", {31'd0, bus.done}, 32'd0);

    // counter wrap: 255 loads then one more
    do_reset();
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (i > 0 && i < 4) chk("wrap_done_run", {31'd0, bus.done}, 32'd1);
      bus.instr_valid = 1'b1;
      bus.instr_load  = 1'b1;
      bus.instr_imm   = WIDTH'(i);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("wrap_cnt255", {24'd0, bus.op_count}, 32'd255);
    chk("wrap_acc254", {27'd0, bus.acc}, 32'h1e);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_imm   = 5'b10101;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("wrap_cnt0", {24'd0, bus.op_count}, 32'd0);
    chk("wrap_acc", {27'd0, bus.acc}, 32'h15);
    chk("wrap_done", {31'd0, bus.done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
